// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types (FSM state enum), data-length codes DB5..DB8 and data_len() helper giving the bit count for a cfg_data_bits code
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  localparam logic [1:0] DB5 = 2'd0;
  localparam logic [1:0] DB6 = 2'd1;
  localparam logic [1:0] DB7 = 2'd2;
  localparam logic [1:0] DB8 = 2'd3;
  function automatic logic [3:0] data_len(input logic [1:0] db);
    return 4'd5 + {2'b00, db};
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: synchronous FIFO (DEPTH power of two), ports clk rst_n push din pop dout full empty level; caller never pushes when full or pops when empty
module uart_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  assign dout  = mem[rd_ptr];
  assign full  = level == LW'(DEPTH);
  assign empty = level == '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= pop ? rd_ptr + AW'(1) : rd_ptr;
      level  <= level + LW'(push) - LW'(pop);
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART tx (5-8 data, none/even/odd parity, 1/2 stop) fed by uart_sync_fifo; ports clk rst_n in_valid/in_data/in_ready baud_div cfg_* tx tx_busy tx_done fifo_level, plus brk when UART_TX_CFG_BREAK_EN is defined
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int BAUD_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
`ifdef UART_TX_CFG_BREAK_EN
  input  logic                          brk,
`endif
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  input  logic [BAUD_W-1:0]             baud_div,
  input  logic [1:0]                    cfg_data_bits,
  input  logic                          cfg_parity_en,
  input  logic                          cfg_parity_odd,
  input  logic                          cfg_stop2,
  output logic                          tx,
  output logic                          tx_busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam logic [BAUD_W-1:0] ONE = BAUD_W'(1);
  state_t            state;
  logic [BAUD_W-1:0] cnt, div_r, eff_div;
  logic [7:0]        shreg, fifo_dout;
  logic [3:0]        nbits;
  logic [2:0]        bit_idx;
  logic              par_r, par_en_r, stop2_r, stop_idx;
  logic              full, empty, push, pop, bit_end, frame_end, can_start, line, line_idle, busy_c;
`ifdef UART_TX_CFG_BREAK_EN
  logic              mark;
  assign can_start = !brk && !mark;
  assign line_idle = !brk;
  assign busy_c    = state != IDLE || brk;
`else
  assign can_start = 1'b1;
  assign line_idle = 1'b1;
  assign busy_c    = state != IDLE;
`endif
  assign eff_div   = baud_div == '0 ? ONE : baud_div;
  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign bit_end   = cnt == div_r - ONE;
  assign frame_end = state == STOP && bit_end && stop_idx == stop2_r;
  assign pop       = !empty && can_start && (state == IDLE || frame_end);
  // line is the value the current state wants on the wire; tx registers it one cycle later
  assign line = state == START  ? 1'b0 :
                state == DATA   ? shreg[0] :
                state == PARITY ? par_r :
                state == STOP   ? 1'b1 : line_idle;
  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (in_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      div_r    <= ONE;
      shreg    <= '0;
      nbits    <= 4'd8;
      bit_idx  <= '0;
      par_r    <= 1'b0;
      par_en_r <= 1'b0;
      stop2_r  <= 1'b0;
      stop_idx <= 1'b0;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
`ifdef UART_TX_CFG_BREAK_EN
      mark     <= 1'b0;
`endif
    end else begin
      tx      <= line;
      tx_busy <= busy_c;
      tx_done <= frame_end;
      if (state != IDLE) cnt <= bit_end ? '0 : cnt + ONE;
      if (pop) begin
        state    <= START;
        cnt      <= '0;
        shreg    <= fifo_dout;
        div_r    <= eff_div;
        nbits    <= data_len(cfg_data_bits);
        bit_idx  <= '0;
        par_r    <= cfg_parity_odd;
        par_en_r <= cfg_parity_en;
        stop2_r  <= cfg_stop2;
        stop_idx <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
`ifdef UART_TX_CFG_BREAK_EN
            // after break release, hold mark for one bit period before popping
            if (brk) begin
              mark <= 1'b1;
              cnt  <= '0;
            end else if (mark) begin
              cnt  <= cnt == eff_div - ONE ? '0 : cnt + ONE;
              mark <= cnt != eff_div - ONE;
            end
`endif
          end
          START:  if (bit_end) state <= DATA;
          DATA: if (bit_end) begin
            shreg   <= shreg >> 1;
            par_r   <= par_r ^ shreg[0];
            bit_idx <= bit_idx + 3'd1;
            if ({1'b0, bit_idx} == nbits - 4'd1) state <= par_en_r ? PARITY : STOP;
          end
          PARITY: if (bit_end) state <= STOP;
          STOP: if (bit_end) begin
            stop_idx <= 1'b1;
            if (stop_idx == stop2_r) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed self-checking bench for uart_tx_cfg (default build)
module tb_uart_tx_cfg;
  localparam int FD = 4;
  localparam int BW = 16;
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic [BW-1:0] baud_div = 16'd4;
  logic [1:0]    cfg_data_bits = 2'd3;
  logic          cfg_parity_en = 1'b0;
  logic          cfg_parity_odd = 1'b0;
  logic          cfg_stop2 = 1'b0;
  logic          tx, tx_busy, tx_done;
  logic [$clog2(FD):0] fifo_level;
  int tests = 0;
  int fails = 0;
  logic cap_tx [256];
  logic cap_busy [256];
  logic cap_done [256];
  logic [7:0] bb [6] = '{8'h3C, 8'hA1, 8'h7E, 8'h05, 8'hF0, 8'h99};
  always #5 clk = ~clk;
  uart_tx_cfg #(.FIFO_DEPTH(FD), .BAUD_W(BW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .in_ready       (in_ready),
    .baud_div       (baud_div),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .cfg_stop2      (cfg_stop2),
    .tx             (tx),
    .tx_busy        (tx_busy),
    .tx_done        (tx_done),
    .fifo_level     (fifo_level)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_low(output int e);
    e = -1;
    for (int i = 1; i <= 50; i++) begin
      tick();
      if (tx === 1'b0) begin
        e = i;
        break;
      end
    end
  endtask
  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_tx[i] = tx;
      cap_busy[i] = tx_busy;
      cap_done[i] = tx_done;
      tick();
    end
  endtask
  task automatic push1(input logic [7:0] d);
    in_valid = 1'b1;
    in_data = d;
    tick();
    in_valid = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL reset_tx got %b want 1", tx); end
    tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", tx_busy); end
    tests++; if (tx_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", tx_done); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %b want 1", in_ready); end
    tests++; if (fifo_level !== 3'd0) begin fails++; $display("FAIL reset_level got %0d want 0", fifo_level); end
    rst_n = 1'b1;
    repeat (3) tick();
    tests++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin fails++; $display("FAIL post_reset_idle got tx=%b busy=%b want 1 0", tx, tx_busy); end
  endtask
  task automatic test_8n1();
    bit ex [10] = '{0,1,0,1,0,0,1,0,1,1};
    int e, el, eb, ed;
    baud_div = 16'd4; cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_stop2 = 1'b0;
    push1(8'hA5);
    wait_low(e);
    tests++; if (e !== 2) begin fails++; $display("FAIL 8n1_latency got %0d want 2", e); end
    capture(40);
    el = 0; eb = 0; ed = 0;
    for (int i = 0; i < 40; i++) begin
      if (cap_tx[i] !== ex[i/4]) el++;
      if (cap_busy[i] !== 1'b1) eb++;
      if (cap_done[i] !== (i == 39)) ed++;
    end
    tests++; if (el != 0) begin fails++; $display("FAIL 8n1_line got %0d bad cycles want 0", el); end
    tests++; if (eb != 0) begin fails++; $display("FAIL 8n1_busy got %0d bad cycles want 0", eb); end
    tests++; if (ed != 0) begin fails++; $display("FAIL 8n1_done got %0d bad cycles want 0", ed); end
    tests++; if (tx !== 1'b1 || tx_busy !== 1'b0 || tx_done !== 1'b0) begin fails++; $display("FAIL 8n1_end got tx=%b busy=%b done=%b want 1 0 0", tx, tx_busy, tx_done); end
  endtask
  task automatic test_7e2();
    bit ee [11] = '{0,1,1,0,0,1,0,1,0,1,1};
    bit eo [11] = '{0,1,1,0,0,1,0,1,1,1,1};
    int e, el, eb, ed;
    for (int p = 0; p < 2; p++) begin
      baud_div = 16'd3; cfg_data_bits = 2'd2; cfg_parity_en = 1'b1; cfg_parity_odd = p[0]; cfg_stop2 = 1'b1;
      push1(8'h53);
      wait_low(e);
      tests++; if (e !== 2) begin fails++; $display("FAIL 7x2_latency p=%0d got %0d want 2", p, e); end
      capture(33);
      el = 0; eb = 0; ed = 0;
      for (int i = 0; i < 33; i++) begin
        if (cap_tx[i] !== (p == 0 ? ee[i/3] : eo[i/3])) el++;
        if (cap_busy[i] !== 1'b1) eb++;
        if (cap_done[i] !== (i == 32)) ed++;
      end
      tests++; if (el != 0) begin fails++; $display("FAIL 7x2_line p=%0d got %0d bad cycles want 0", p, el); end
      tests++; if (eb != 0 || ed != 0) begin fails++; $display("FAIL 7x2_busy_done p=%0d got %0d/%0d bad cycles want 0/0", p, eb, ed); end
      tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL 7x2_end p=%0d got busy=%b want 0", p, tx_busy); end
    end
  endtask
  task automatic test_5o1();
    bit ex [8] = '{0,1,1,1,1,1,0,1};
    int e, el, ed;
    baud_div = 16'd2; cfg_data_bits = 2'd0; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b1; cfg_stop2 = 1'b0;
    push1(8'hFF);
    wait_low(e);
    capture(16);
    el = 0; ed = 0;
    for (int i = 0; i < 16; i++) begin
      if (cap_tx[i] !== ex[i/2]) el++;
      if (cap_done[i] !== (i == 15)) ed++;
    end
    tests++; if (el != 0) begin fails++; $display("FAIL 5o1_line got %0d bad cycles want 0", el); end
    tests++; if (ed != 0) begin fails++; $display("FAIL 5o1_done got %0d bad cycles want 0", ed); end
    tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL 5o1_end got busy=%b want 0", tx_busy); end
  endtask
  task automatic test_back_to_back();
    int k, badr, maxl, e, el, eb, ed, f, j;
    logic rdy;
    logic exb;
    baud_div = 16'd2; cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    k = 0; badr = 0; maxl = 0;
    fork
      begin
        in_valid = 1'b1;
        in_data = bb[0];
        for (int c = 0; c < 200 && k < 6; c++) begin
          rdy = in_ready;
          if (in_ready !== (fifo_level != 3'd4)) badr++;
          if (int'(fifo_level) > maxl) maxl = int'(fifo_level);
          tick();
          if (rdy) k++;
          if (k < 6) in_data = bb[k];
          else in_valid = 1'b0;
        end
        in_valid = 1'b0;
      end
      begin
        wait_low(e);
        capture(120);
      end
    join
    el = 0; eb = 0; ed = 0;
    for (int i = 0; i < 120; i++) begin
      f = i / 20;
      j = (i % 20) / 2;
      exb = j == 0 ? 1'b0 : j == 9 ? 1'b1 : bb[f][j-1];
      if (cap_tx[i] !== exb) el++;
      if (cap_busy[i] !== 1'b1) eb++;
      if (cap_done[i] !== (i % 20 == 19)) ed++;
    end
    tests++; if (k != 6) begin fails++; $display("FAIL b2b_pushed got %0d want 6", k); end
    tests++; if (maxl != 4) begin fails++; $display("FAIL b2b_max_level got %0d want 4", maxl); end
    tests++; if (badr != 0) begin fails++; $display("FAIL b2b_ready got %0d bad cycles want 0", badr); end
    tests++; if (el != 0) begin fails++; $display("FAIL b2b_line got %0d bad cycles want 0", el); end
    tests++; if (eb != 0) begin fails++; $display("FAIL b2b_busy_gap got %0d bad cycles want 0", eb); end
    tests++; if (ed != 0) begin fails++; $display("FAIL b2b_done got %0d bad cycles want 0", ed); end
    tests++; if (tx_busy !== 1'b0 || fifo_level !== 3'd0) begin fails++; $display("FAIL b2b_end got busy=%b level=%0d want 0 0", tx_busy, fifo_level); end
  endtask
  task automatic test_div0_cfg();
    bit ex [19] = '{0,1,1,0,0,0,0,1,1,1, 0,1,0,1,1,0,1,1,1};
    int e, el, eb, ed;
    baud_div = 16'd0; cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    in_valid = 1'b1;
    in_data = 8'hC3;
    tick();
    in_data = 8'h2D;
    tick();
    in_valid = 1'b0;
    cfg_data_bits = 2'd0; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b1;
    wait_low(e);
    tests++; if (e !== 1) begin fails++; $display("FAIL div0_latency got %0d want 1", e); end
    capture(19);
    el = 0; eb = 0; ed = 0;
    for (int i = 0; i < 19; i++) begin
      if (cap_tx[i] !== ex[i]) el++;
      if (cap_busy[i] !== 1'b1) eb++;
      if (cap_done[i] !== (i == 9 || i == 18)) ed++;
    end
    tests++; if (el != 0) begin fails++; $display("FAIL div0_line got %0d bad cycles want 0", el); end
    tests++; if (eb != 0) begin fails++; $display("FAIL div0_busy got %0d bad cycles want 0", eb); end
    tests++; if (ed != 0) begin fails++; $display("FAIL div0_done got %0d bad cycles want 0", ed); end
    tests++; if (tx_busy !== 1'b0) begin fails++; $display("FAIL div0_end got busy=%b want 0", tx_busy); end
  endtask
  task automatic test_reset_mid();
    int bad;
    baud_div = 16'd4; cfg_data_bits = 2'd3; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0; cfg_stop2 = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h00;
    tick();
    in_data = 8'h55;
    tick();
    in_data = 8'h11;
    tick();
    in_valid = 1'b0;
    repeat (12) tick();
    tests++; if (tx !== 1'b0 || fifo_level !== 3'd2) begin fails++; $display("FAIL rstmid_pre got tx=%b level=%0d want 0 2", tx, fifo_level); end
    rst_n = 1'b0;
    #1;
    tests++; if (tx !== 1'b1) begin fails++; $display("FAIL rstmid_async_tx got %b want 1", tx); end
    tests++; if (fifo_level !== 3'd0 || tx_busy !== 1'b0) begin fails++; $display("FAIL rstmid_state got level=%0d busy=%b want 0 0", fifo_level, tx_busy); end
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
    end
    tests++; if (bad != 0) begin fails++; $display("FAIL rstmid_residual got %0d active cycles want 0", bad); end
  endtask
  initial begin
    test_reset();
    test_8n1();
    test_7e2();
    test_5o1();
    test_back_to_back();
    test_div0_cfg();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
